// File: rtl/mul_unit_arbiter_pkg.sv
// Shared definitions for the accelerator controllers that front the booth multiplier.
// Latency: none (types and constants only).
// Backpressure: none.
package mul_unit_arbiter_pkg;

  // Controller sequencing: pick owner, kick the unit, wait for it, report.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Cycles a controller waits for unit_done before giving up on the unit.
  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/mul_unit_arbiter_rr_priority_picker.sv
// Round-robin winner select: first asserted req at or after ptr, wrapping at NUM_REQ-1.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the winner.
module rr_priority_picker
  import mul_unit_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner
);

  // One spare bit so ptr + offset never wraps before the modulo correction.
  localparam int IW = PTR_W + 1;

  logic [IW-1:0] idx;
  logic          found;

  // Walk the requesters starting at ptr and take the first one that is asking.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'(ptr) + IW'(i);
      if (idx >= IW'(NUM_REQ)) begin
        idx = idx - IW'(NUM_REQ);
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (idx == IW'(j))) begin
          winner[j] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mul_unit_arbiter.sv
// Shares one booth multiplier between NUM_REQ requesters with round-robin ownership and a watchdog.
// Latency: req to resp_valid is 3 cycles plus the unit latency; one idle cycle between owners.
// Backpressure: requesters hold req until granted; the unit is given TIMEOUT cycles before abort.
module mul_unit_arbiter
  import mul_unit_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REQ   = 3,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   op_a,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   op_b,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [WORD_SIZE-1:0]           result,
  output logic                           overflow,
  output logic                           timeout_err,
  output logic                           unit_start,
  output logic [WORD_SIZE-1:0]           unit_op_a,
  output logic [WORD_SIZE-1:0]           unit_op_b,
  input  logic [WORD_SIZE-1:0]           unit_result,
  input  logic                           unit_overflow,
  input  logic                           unit_done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  arb_state_t           state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     next_ptr;
  logic [WD_W-1:0]      wdog;
  logic [NUM_REQ-1:0]   winner;
  logic [WORD_SIZE-1:0] sel_a;
  logic [WORD_SIZE-1:0] sel_b;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (winner)
  );

  // Route the winner's operand slices and work out where the next search starts.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    next_ptr = rr_ptr;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (winner[j]) begin
        sel_a    = op_a[j*WORD_SIZE +: WORD_SIZE];
        sel_b    = op_b[j*WORD_SIZE +: WORD_SIZE];
        next_ptr = (j == NUM_REQ - 1) ? '0 : PTR_W'(j + 1);
      end
    end
  end

  // Ownership FSM; every output is a register so the unit and requesters see clean levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      resp_valid  <= '0;
      unit_start  <= 1'b0;
      unit_op_a   <= '0;
      unit_op_b   <= '0;
      result      <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      wdog        <= '0;
      rr_ptr      <= '0;
    end else begin
      unit_start <= 1'b0;
      resp_valid <= '0;
      case (state)
        ST_IDLE: begin
          // Any request always yields a winner, so no need to check winner itself.
          if (|req) begin
            grant      <= winner;
            unit_op_a  <= sel_a;
            unit_op_b  <= sel_b;
            rr_ptr     <= next_ptr;
            unit_start <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wdog  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done in the expiry cycle still counts as a real completion.
          if (unit_done) begin
            result      <= unit_result;
            overflow    <= unit_overflow;
            timeout_err <= 1'b0;
            resp_valid  <= grant;
            state       <= ST_RESP;
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            result      <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b1;
            resp_valid  <= grant;
            state       <= ST_RESP;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        ST_RESP: begin
          grant <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_unit_arbiter.md
MUL_UNIT_ARBITER -- requirements
Module: mul_unit_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, operand/result width (Q8.7 fixed point, matching the datapath).
REQ-002 SHALL have parameter NUM_REQ, default 3, number of requesters (2..8).
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum cycles to wait for unit_done before aborting.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester request level.
REQ-007 SHALL have port op_a  input  NUM_REQ*WORD_SIZE  packed operand A; slice i belongs to requester i.
REQ-008 SHALL have port op_b  input  NUM_REQ*WORD_SIZE  packed operand B.
REQ-009 SHALL have port grant  output  NUM_REQ  one-hot owner of the shared multiplier; all zero when idle.
REQ-010 SHALL have port resp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse.
REQ-011 SHALL have port result  output  WORD_SIZE  product for the pulsed requester.
REQ-012 SHALL have port overflow  output  1  unit overflow, qualified by resp_valid.
REQ-013 SHALL have port timeout_err  output  1  abort flag, qualified by resp_valid.
REQ-014 SHALL have ports unit_start (output, 1), unit_op_a and unit_op_b (output, WORD_SIZE), unit_result (input, WORD_SIZE), unit_overflow (input, 1) and unit_done (input, 1), forming the shared booth multiplier handshake.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-016 IDLE: when any req bit is high, SHALL register the round-robin winner into grant and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-017 Round-robin: search SHALL start at the index one past the last granted requester, wrapping from NUM_REQ-1 to 0; after reset the search SHALL start at index 0.
REQ-018 ISSUE: unit_start SHALL be high for exactly one cycle, the watchdog counter SHALL clear, and the FSM SHALL go to WAIT.
REQ-019 unit_op_a and unit_op_b SHALL be registered from the granted slices in the IDLE-to-ISSUE cycle and held constant until the FSM returns to IDLE.
REQ-020 WAIT: on unit_done, SHALL capture unit_result and unit_overflow, clear timeout_err, and go to RESP.
REQ-021 WAIT: after TIMEOUT cycles without unit_done, SHALL set result to 0, overflow to 0 and timeout_err to 1, and go to RESP.
REQ-022 A unit_done arriving in the same cycle the timeout expires SHALL take precedence, giving a normal completion.
REQ-023 RESP: resp_valid SHALL equal grant for one cycle; the next state SHALL be IDLE with grant cleared.
REQ-024 result, overflow and timeout_err SHALL hold their value until the next RESP.
REQ-025 Minimum latency from req to resp_valid SHALL be 3 cycles plus the unit latency; back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-026 unit_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-027 Deasserting req after grant SHALL NOT abort the operation; the response SHALL still be pulsed.
REQ-028 A requester SHALL drop req in the cycle after its resp_valid; a req still high in IDLE is treated as a new request.

Reset
REQ-029 While rst is low, SHALL force: state IDLE; grant, resp_valid, unit_start, unit_op_a, unit_op_b, result, overflow, timeout_err, watchdog counter and round-robin pointer all 0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no resp_valid.

Structure
REQ-031 SHALL place the FSM state encoding and the default TIMEOUT constant in the shared package used by the accelerator controllers.
REQ-032 SHALL implement the round-robin winner selection as sub-module rr_priority_picker (combinational, inputs req and pointer, output one-hot winner).

Verification
REQ-033 req=001, op_a=0x0100 (2.0), op_b=0x0180 (3.0), unit returns 0x0300 after 8 cycles -> unit_start pulses once with those operands; resp_valid=001, result=0x0300, overflow=0, timeout_err=0.
REQ-034 req=111 held continuously -> grants follow 001, 010, 100, 001 with no starvation.
REQ-035 unit_done never asserts -> resp_valid pulses after exactly 64 WAIT cycles with timeout_err=1 and result=0.
REQ-036 unit_done and timeout expiry in the same cycle -> normal completion with timeout_err=0; a spurious unit_done in IDLE has no effect.
REQ-037 rst driven low during WAIT -> all outputs 0 immediately, no resp_valid; the next request after reset is granted to requester 0 when req=011.
REQ-038 Requester drops req one cycle after grant -> its resp_valid still arrives with the correct product.
